// File: rtl/ex_seq_ctrl.sv
// rtl/ex_seq_ctrl.sv - EX stage sequencer dispatching single- and multi-cycle ops
module ex_seq_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       start_i,
    input  logic [3:0] unit_sel_i,
    input  logic [3:0] unit_done_i,
    output logic [3:0] unit_start_o,
    output logic       ready_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       illegal_o,
    output logic       timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state, state_next;
    logic [3:0] sel_q, sel_next;
    logic [7:0] cnt, cnt_next, cnt_inc;
    logic       accept, sel_zero, sel_onehot, sel_hit, expired;

    assign ready_o    = (state == S_IDLE) && !clear;
    // Gating with rst_n keeps every pulse output low while reset is held.
    assign accept     = start_i && ready_o && rst_n;
    assign sel_zero   = (unit_sel_i == 4'd0);
    assign sel_onehot = !sel_zero && ((unit_sel_i & (unit_sel_i - 4'd1)) == 4'd0);
    assign sel_hit    = |(unit_done_i & sel_q);
    assign expired    = (cnt == TIMEOUT_LAST);
    assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign busy_o     = (state == S_WAIT) || (state == S_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel_q <= 4'd0;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            sel_q <= sel_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        sel_next     = sel_q;
        cnt_next     = cnt;
        unit_start_o = 4'd0;
        done_o       = 1'b0;
        illegal_o    = 1'b0;
        timeout_o    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (sel_zero) begin
                        done_o = 1'b1;
                    end else if (!sel_onehot) begin
                        done_o    = 1'b1;
                        illegal_o = 1'b1;
                    end else begin
                        unit_start_o = unit_sel_i;
                        sel_next     = unit_sel_i;
                        cnt_next     = 8'd0;
                        state_next   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt_inc;
                // A flush in the completing cycle still retires the unit, but the pipeline must not advance.
                if (sel_hit) begin
                    done_o     = !clear;
                    state_next = S_IDLE;
                end else if (expired) begin
                    timeout_o  = 1'b1;
                    done_o     = !clear;
                    state_next = S_IDLE;
                end else if (clear) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_next = cnt_inc;
                if (sel_hit) begin
                    state_next = S_IDLE;
                end else if (expired) begin
                    timeout_o  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
